// File: rtl/press_counter_scan.sv
// Debounced two-button hex press counter that time-multiplexes its four nibbles
// onto a 7-segment decoder input, with anodes lagging one cycle behind.
module press_counter_scan #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_CYCLES     = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_inc,
  input  logic        btn_clr,
  output logic [3:0]  number,
  output logic [3:0]  an,
  output logic [15:0] count,
  output logic        press_pulse
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_CYCLES - 1);
  localparam int B_INC = 0;
  localparam int B_CLR = 1;

  logic [1:0]         s1_q, s1_d;
  logic [1:0]         s2_q, s2_d;
  logic [1:0]         lvl_q, lvl_d;
  logic [1:0]         lvl_prev_q, lvl_prev_d;
  logic [1:0][DW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]         rise_s;

  logic [15:0]        count_q, count_d;
  logic               pulse_q, pulse_d;

  logic [SW-1:0]      scan_cnt_q, scan_cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [1:0]         idx_prev_q, idx_prev_d;
  logic [3:0]         number_q, number_d;
  logic [3:0]         an_q, an_d;

  // Two-flop synchroniser and per-button debounce counters.
  always_comb begin
    s1_d       = {btn_clr, btn_inc};
    s2_d       = s1_q;
    lvl_d      = lvl_q;
    lvl_prev_d = lvl_q;
    db_cnt_d   = db_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] == lvl_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_MAX) begin
        // Level held long enough: accept it and start afresh.
        lvl_d[i]    = s2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + {{(DW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Rising edges of the debounced levels drive the counter; clear dominates.
  always_comb begin
    rise_s  = lvl_q & ~lvl_prev_q;
    count_d = count_q;
    pulse_d = 1'b0;
    if (rise_s[B_CLR]) begin
      count_d = 16'h0000;
      pulse_d = 1'b0;
    end else if (rise_s[B_INC]) begin
      count_d = count_q + 16'h0001;
      pulse_d = 1'b1;
    end else begin
      count_d = count_q;
      pulse_d = 1'b0;
    end
  end

  // Digit scan: slot timer, index, nibble select and one-cycle-late anodes.
  always_comb begin
    idx_prev_d = idx_q;
    if (scan_cnt_q == SCAN_MAX) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end else begin
      scan_cnt_d = scan_cnt_q + {{(SW-1){1'b0}}, 1'b1};
      idx_d      = idx_q;
    end
    case (idx_q)
      2'd0:    number_d = count_q[3:0];
      2'd1:    number_d = count_q[7:4];
      2'd2:    number_d = count_q[11:8];
      2'd3:    number_d = count_q[15:12];
      default: number_d = 4'h0;
    endcase
    an_d = ~(4'b0001 << idx_prev_q);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= 2'b00;
      s2_q       <= 2'b00;
      lvl_q      <= 2'b00;
      lvl_prev_q <= 2'b00;
      db_cnt_q   <= '0;
      count_q    <= 16'h0000;
      pulse_q    <= 1'b0;
      scan_cnt_q <= '0;
      idx_q      <= 2'd0;
      idx_prev_q <= 2'd0;
      number_q   <= 4'h0;
      an_q       <= 4'b1111;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_prev_d;
      db_cnt_q   <= db_cnt_d;
      count_q    <= count_d;
      pulse_q    <= pulse_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      idx_prev_q <= idx_prev_d;
      number_q   <= number_d;
      an_q       <= an_d;
    end
  end

  assign number      = number_q;
  assign an          = an_q;
  assign count       = count_q;
  assign press_pulse = pulse_q;

endmodule

// File: tb/tb_press_counter_scan.sv
// Directed bench for press_counter_scan with a cycle-level reference model.
module tb_press_counter_scan;

  localparam int D = 4;
  localparam int S = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_inc = 1'b0;
  logic        btn_clr = 1'b0;
  logic [3:0]  number;
  logic [3:0]  an;
  logic [15:0] count;
  logic        press_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  press_counter_scan #(.DEBOUNCE_CYCLES(D), .SCAN_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .btn_inc(btn_inc), .btn_clr(btn_clr),
    .number(number), .an(an), .count(count), .press_pulse(press_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: raw-sample history, accept a level after D differing synced samples.
  int          n_edge;
  bit [15:0]   m_count;
  bit [3:0]    m_number, m_an;
  bit          m_pulse;
  bit [D:0]    h_inc, h_clr;
  bit          lvl_inc, lvl_clr, rose_inc, rose_clr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_edge = 0; m_count = 16'h0; m_number = 4'h0; m_an = 4'hF; m_pulse = 1'b0;
      h_inc = '0; h_clr = '0; lvl_inc = 1'b0; lvl_clr = 1'b0;
      rose_inc = 1'b0; rose_clr = 1'b0;
    end else begin
      n_edge++;
      m_number = 4'((m_count >> (4 * (((n_edge - 1) / S) % 4))) & 16'hF);
      m_an     = ~(4'b0001 << (((n_edge - 2) / S) % 4));
      if (rose_clr) begin m_count = 16'h0; m_pulse = 1'b0; end
      else if (rose_inc) begin m_count = m_count + 16'h1; m_pulse = 1'b1; end
      else m_pulse = 1'b0;
      rose_inc = 1'b0; rose_clr = 1'b0;
      if (h_inc[D:1] == {D{~lvl_inc}}) begin lvl_inc = ~lvl_inc; rose_inc = lvl_inc; end
      if (h_clr[D:1] == {D{~lvl_clr}}) begin lvl_clr = ~lvl_clr; rose_clr = lvl_clr; end
      h_inc = {h_inc[D-1:0], btn_inc};
      h_clr = {h_clr[D-1:0], btn_clr};
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    chk("m_count", count, m_count);
    chk("m_number", {12'h0, number}, {12'h0, m_number});
    chk("m_pulse", {15'h0, press_pulse}, {15'h0, m_pulse});
    if (n_edge != 1) chk("m_an", {12'h0, an}, {12'h0, m_an});
  end

  task automatic press_inc();
    btn_inc = 1'b1; repeat (10) @(negedge clk);
    btn_inc = 1'b0; repeat (10) @(negedge clk);
  endtask

  task automatic press_clr();
    btn_clr = 1'b1; repeat (10) @(negedge clk);
    btn_clr = 1'b0; repeat (10) @(negedge clk);
  endtask

  task automatic force_count(input logic [15:0] v);
    @(posedge clk); #2;
    force dut.count_q = v;
    m_count = v;
    @(posedge clk); #1;
    release dut.count_q;
    @(negedge clk);
  endtask

  // Waits for press_pulse after an input change made at a negedge; returns edge index or 0.
  task automatic wait_pulse(output int found);
    found = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (press_pulse && found == 0) begin found = e; break; end
    end
  endtask

  initial begin
    int found;
    int pulses;
    logic [3:0] prev;
    logic [3:0] exp_num [6];
    logic [3:0] exp_an  [6];
    exp_num = '{4'h4, 4'h4, 4'h4, 4'h3, 4'h3, 4'h3};
    exp_an  = '{4'b0111, 4'b1110, 4'b1110, 4'b1110, 4'b1101, 4'b1101};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: mid-cycle reset and first edges after release
    @(posedge clk); #2; rst_n = 1'b0; #1;
    chk("rst_count", count, 16'h0000);
    chk("rst_number", {12'h0, number}, 16'h0);
    chk("rst_an", {12'h0, an}, 16'h000F);
    chk("rst_pulse", {15'h0, press_pulse}, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_an", {12'h0, an}, 16'h000E);
    chk("post_rst_number", {12'h0, number}, 16'h0);

    // 2: bouncing increment, then held
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      btn_inc = ((i / 2) % 2) == 0;
      @(negedge clk);
    end
    btn_inc = 1'b1;
    wait_pulse(found);
    chk("bounce_latency", 16'(found), 16'd7);
    chk("bounce_count", count, 16'h0001);
    repeat (10) @(negedge clk);
    btn_inc = 1'b0;
    repeat (10) @(negedge clk);
    chk("bounce_hold_count", count, 16'h0001);

    // Bring count to 5
    for (int i = 0; i < 4; i++) press_inc();
    chk("five_count", count, 16'h0005);

    // 4: simultaneous inc and clr
    btn_inc = 1'b1; btn_clr = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (press_pulse) pulses++;
    end
    chk("simul_pulses", 16'(pulses), 16'd0);
    chk("simul_count", count, 16'h0000);
    btn_inc = 1'b0; btn_clr = 1'b0;
    repeat (10) @(negedge clk);

    // 3: wrap from FFFF
    force_count(16'hFFFF);
    chk("forced_count", count, 16'hFFFF);
    btn_inc = 1'b1;
    wait_pulse(found);
    chk("wrap_latency", 16'(found), 16'd7);
    chk("wrap_count", count, 16'h0000);
    @(negedge clk); btn_inc = 1'b0;
    repeat (10) @(negedge clk);

    // 5: scan sequence with count 1234
    force_count(16'h1234);
    prev = number;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (number == 4'h4 && prev == 4'h1) begin found = 1; break; end
      prev = number;
    end
    chk("scan_found", 16'(found), 16'd1);
    for (int k = 0; k < 6; k++) begin
      chk("scan_number", {12'h0, number}, {12'h0, exp_num[k]});
      chk("scan_an", {12'h0, an}, {12'h0, exp_an[k]});
      @(negedge clk);
    end
    press_clr();
    chk("clr_count", count, 16'h0000);

    // 6: reset while the button is held
    press_inc(); press_inc();
    btn_inc = 1'b1;
    wait_pulse(found);
    chk("held_count", count, 16'h0003);
    repeat (4) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    chk("held_rst_count", count, 16'h0000);
    chk("held_rst_pulse", {15'h0, press_pulse}, 16'h0);
    @(negedge clk); rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      if (e == 6) chk("rerise_early", count, 16'h0000);
      if (e == 7) chk("rerise_count", count, 16'h0001);
    end
    @(negedge clk); btn_inc = 1'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
